// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit: shift-add multiply and restoring divide, BITS_PER_CYCLE steps per cycle.
// Optional build macro MULDIV_FAST_ZERO_EN: zero-operand MUL/DIV/REM finish in one cycle with result 0.
module ex_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      w_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_req_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            w_enable_o,
    output logic [4:0]      w_addr_o
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0]   LAST_STEP = CW'(N - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t          state_q;
    logic [2:0]      op_q;
    logic            negRes_q;
    logic [4:0]      addr_q;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic            wen_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      waddr_q;

    logic            isDiv, signedA, signedB, negA, negB, negRes_d;
    logic [XLEN-1:0] magA, magB;
    logic            divZero, divOvf, fastZero, special;
    logic [XLEN-1:0] specRes;
    logic [XLEN-1:0] hiStep, loStep;
    logic [XLEN:0]   tmp;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0] quoFix, remFix, finalRes;

    // Operand decode: signed ops iterate on magnitudes, sign is restored in FIXUP.
    always_comb begin
        isDiv    = op_i[2];
        signedA  = (op_i != 3'd3) && (op_i != 3'd5) && (op_i != 3'd7);
        signedB  = signedA && (op_i != 3'd2);
        negA     = signedA & rs1_i[XLEN-1];
        negB     = signedB & rs2_i[XLEN-1];
        magA     = negA ? -rs1_i : rs1_i;
        magB     = negB ? -rs2_i : rs2_i;
        negRes_d = (isDiv && op_i[1]) ? negA : (negA ^ negB);
    end

    always_comb begin
        divZero = isDiv && (rs2_i == '0);
        divOvf  = isDiv && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
`ifdef MULDIV_FAST_ZERO_EN
        fastZero = isDiv ? ((rs1_i == '0) && (rs2_i != '0))
                         : ((rs1_i == '0) || (rs2_i == '0));
`else
        fastZero = 1'b0;
`endif
        special = divZero || divOvf || fastZero;
        specRes = '0;
        if (divZero)
            specRes = op_i[1] ? rs1_i : '1;
        else if (divOvf)
            specRes = op_i[1] ? '0 : rs1_i;
    end

    // {hi,lo} is the product accumulator for multiply and {remainder,quotient} for divide.
    always_comb begin
        hiStep = hi_q;
        loStep = lo_q;
        tmp    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                tmp    = {hiStep, loStep[XLEN-1]};
                loStep = {loStep[XLEN-2:0], 1'b0};
                if (tmp >= {1'b0, opnd_q}) begin
                    tmp       = tmp - {1'b0, opnd_q};
                    loStep[0] = 1'b1;
                end
                hiStep = tmp[XLEN-1:0];
            end else begin
                tmp    = {1'b0, hiStep} + (loStep[0] ? {1'b0, opnd_q} : '0);
                loStep = {tmp[0], loStep[XLEN-1:1]};
                hiStep = tmp[XLEN:1];
            end
        end
    end

    always_comb begin
        prodFix = negRes_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quoFix  = negRes_q ? -lo_q : lo_q;
        remFix  = negRes_q ? -hi_q : hi_q;
        case (op_q)
            3'd0:       finalRes = prodFix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       finalRes = prodFix[2*XLEN-1:XLEN];
            3'd4, 3'd5: finalRes = quoFix;
            default:    finalRes = remFix;
        endcase
    end

    // IDLE and DONE share acceptance so a start held in DONE chains straight into the next op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            negRes_q <= 1'b0;
            addr_q   <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            wen_q    <= 1'b0;
            result_q <= '0;
            waddr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            wen_q  <= 1'b0;
            case (state_q)
                CALC: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        hi_q  <= hiStep;
                        lo_q  <= loStep;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_STEP)
                            state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        wen_q    <= (addr_q != 5'd0);
                        waddr_q  <= addr_q;
                        result_q <= (addr_q != 5'd0) ? finalRes : '0;
                    end
                end
                default: begin
                    if (flush_i || !start_i) begin
                        state_q <= IDLE;
                    end else begin
                        op_q     <= op_i;
                        addr_q   <= w_addr_i;
                        negRes_q <= negRes_d;
                        opnd_q   <= isDiv ? magB : magA;
                        hi_q     <= '0;
                        lo_q     <= isDiv ? magA : magB;
                        cnt_q    <= '0;
                        if (special) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            wen_q    <= (w_addr_i != 5'd0);
                            waddr_q  <= w_addr_i;
                            result_q <= (w_addr_i != 5'd0) ? specRes : '0;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
            endcase
        end
    end

    assign busy_o      = (state_q == CALC) || (state_q == FIXUP);
    assign stall_req_o = (start_i && ((state_q == IDLE) || (state_q == DONE))) || busy_o;
    assign done_o      = done_q;
    assign w_enable_o  = wen_q;
    assign result_o    = result_q;
    assign w_addr_o    = waddr_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M vectors, special cases,
// flush/reset abort, zero-address write-back, back-to-back issue and a BITS_PER_CYCLE=4 instance.
module tb_ex_muldiv_unit;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic [4:0]  wAddr;
    logic        busy, stallReq, done, wEnable;
    logic [31:0] result;
    logic [4:0]  wAddrOut;

    logic        start4;
    logic [2:0]  op4;
    logic [31:0] rs1x4, rs2x4;
    logic        busy4, stall4, done4, wEnable4;
    logic [31:0] result4;
    logic [4:0]  wAddrOut4;

    typedef struct {
        logic [31:0] result;
        logic        wen;
        logic [4:0]  waddr;
        int          cycle;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  addr;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycleCount = 0;

    vec_t vecs [16] = '{
        '{OP_MULH,   32'h80000000, 32'h80000000, 5'd3,  32'h40000000, LAT},
        '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, LAT},
        '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd6,  32'hFFFFFFFF, LAT},
        '{OP_MUL,    32'hFFFFFFFD, 32'd5,        5'd7,  32'hFFFFFFF1, LAT},
        '{OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, LAT},
        '{OP_REM,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, LAT},
        '{OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD, LAT},
        '{OP_REM,    32'd7,        32'hFFFFFFFE, 5'd20, 32'd1,        LAT},
        '{OP_DIVU,   32'd100,      32'd7,        5'd10, 32'd14,       LAT},
        '{OP_REMU,   32'd100,      32'd7,        5'd11, 32'd2,        LAT},
        '{OP_DIVU,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'd1,        LAT},
        '{OP_MUL,    32'd0,        32'd5,        5'd22, 32'd0,        LAT},
        '{OP_DIVU,   32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1},
        '{OP_REM,    32'd5,        32'd0,        5'd13, 32'd5,        1},
        '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1},
        '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1}
    };

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
        .w_addr_i(wAddr), .flush_i(flush), .busy_o(busy), .stall_req_o(stallReq),
        .done_o(done), .result_o(result), .w_enable_o(wEnable), .w_addr_o(wAddrOut)
    );

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .op_i(op4), .rs1_i(rs1x4), .rs2_i(rs2x4),
        .w_addr_i(5'd1), .flush_i(1'b0), .busy_o(busy4), .stall_req_o(stall4),
        .done_o(done4), .result_o(result4), .w_enable_o(wEnable4), .w_addr_o(wAddrOut4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    function automatic void checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endfunction

    task automatic pushExp(input logic [31:0] res, input logic [4:0] addr, input int cyc);
        exp_t e;
        e.result = (addr == 5'd0) ? 32'd0 : res;
        e.wen    = (addr != 5'd0);
        e.waddr  = addr;
        e.cycle  = cyc;
        sb.push_back(e);
    endtask

    // Called at #1 after a rising edge; lat <= 0 means the op is expected to be aborted.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] addr, input logic [31:0] res, input int lat);
        op = o; rs1 = a; rs2 = b; wAddr = addr; start = 1'b1;
        if (lat > 0)
            pushExp(res, addr, cycleCount + lat);
        @(negedge clk);
        checkOutput("stall_at_accept", 64'(stallReq), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: every done strobe must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("result", 64'(result), 64'(e.result));
                    checkOutput("w_enable", 64'(wEnable), 64'(e.wen));
                    checkOutput("w_addr", 64'(wAddrOut), 64'(e.waddr));
                    checkOutput("done_cycle", 64'(cycleCount), 64'(e.cycle));
                end
            end else if (wEnable) begin
                checkOutput("wen_without_done", 64'(wEnable), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycleCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lows;
        int t0;
        int seen;
        logic [2:0]  ops4 [2];
        logic [31:0] a4 [2];
        logic [31:0] b4 [2];
        logic [31:0] r4 [2];
        ops4[0] = OP_MUL;  a4[0] = 32'd7;   b4[0] = 32'd6; r4[0] = 32'd42;
        ops4[1] = OP_DIVU; a4[1] = 32'd100; b4[1] = 32'd7; r4[1] = 32'd14;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0; wAddr = '0;
        start4 = 1'b0; op4 = '0; rs1x4 = '0; rs2x4 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_wen", 64'(wEnable), 64'd0);
        checkOutput("reset_stall", 64'(stallReq), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_waddr", 64'(wAddrOut), 64'd0);
        @(posedge clk); #1;

        $display("[TB] basic MUL with stall window");
        applyStimulus(OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, LAT);
        lows = 0;
        repeat (33) begin
            @(negedge clk);
            if (!stallReq) lows++;
        end
        checkOutput("stall_hold_cycles_low", 64'(lows), 64'd0);
        @(negedge clk);
        checkOutput("stall_in_done", 64'(stallReq), 64'd0);
        drain(10);

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].addr, vecs[i].res, vecs[i].lat);
            drain(60);
        end

        $display("[TB] flush mid-calculation");
        applyStimulus(OP_MUL, 32'd9, 32'd9, 5'd5, 32'd0, 0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_flush", 64'(busy), 64'd0);
        @(posedge clk); #1;
        applyStimulus(OP_MUL, 32'd11, 32'd12, 5'd6, 32'd132, LAT);
        drain(60);

        $display("[TB] flush during DONE keeps the strobe");
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 5'd2, 32'hFFFFFFFF, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drain(10);

        $display("[TB] reset mid-calculation");
        applyStimulus(OP_MUL, 32'd9, 32'd9, 5'd5, 32'd0, 0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_wen", 64'(wEnable), 64'd0);
        checkOutput("rst_stall", 64'(stallReq), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_waddr", 64'(wAddrOut), 64'd0);
        @(posedge clk); #1;

        $display("[TB] zero destination register");
        applyStimulus(OP_MUL, 32'd3, 32'd3, 5'd0, 32'd9, LAT);
        drain(60);

        $display("[TB] back-to-back with start held high");
        op = OP_MUL; rs1 = 32'd20; rs2 = 32'd30; wAddr = 5'd17; start = 1'b1;
        pushExp(32'd600, 5'd17, cycleCount + LAT);
        repeat (LAT) begin @(posedge clk); #1; end
        op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; wAddr = 5'd18;
        pushExp(32'd333, 5'd18, cycleCount + LAT);
        @(posedge clk); #1;
        start = 1'b0;
        drain(80);

        $display("[TB] BITS_PER_CYCLE=4 instance");
        for (int i = 0; i < 2; i++) begin
            op4 = ops4[i]; rs1x4 = a4[i]; rs2x4 = b4[i]; start4 = 1'b1;
            t0 = cycleCount;
            @(posedge clk); #1;
            start4 = 1'b0;
            seen = -1;
            for (int c = 0; c < 20 && seen < 0; c++) begin
                @(negedge clk);
                if (done4) begin
                    seen = cycleCount - t0;
                    checkOutput("bpc4_result", 64'(result4), 64'(r4[i]));
                    checkOutput("bpc4_wen", 64'(wEnable4), 64'd1);
                    checkOutput("bpc4_waddr", 64'(wAddrOut4), 64'd1);
                    checkOutput("bpc4_busy_in_done", 64'(busy4 | stall4), 64'd0);
                end
            end
            checkOutput("bpc4_latency", 64'(seen), 64'd10);
            @(posedge clk); #1;
        end

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
